// File: rtl/demux_scheduler_if.sv
// Requester, destination and demultiplexor signals of the demux scheduler.
// The master drives the requests and busy inputs; the slave is the scheduler.
interface demux_scheduler_if;
    logic       req0Valid;
    logic       req0Dest;
    logic [8:0] req0Data;
    logic       req0Ready;
    logic       req1Valid;
    logic       req1Dest;
    logic [8:0] req1Data;
    logic       req1Ready;
    logic       destBusyA;
    logic       destBusyB;
    logic [8:0] muxData;
    logic       muxSel;
    logic       loadA;
    logic       loadB;
    logic       busy;
    logic       dropErr;

    modport master (
        output req0Valid, req0Dest, req0Data,
        output req1Valid, req1Dest, req1Data,
        output destBusyA, destBusyB,
        input  req0Ready, req1Ready,
        input  muxData, muxSel, loadA, loadB, busy, dropErr
    );

    modport slave (
        input  req0Valid, req0Dest, req0Data,
        input  req1Valid, req1Dest, req1Data,
        input  destBusyA, destBusyB,
        output req0Ready, req1Ready,
        output muxData, muxSel, loadA, loadB, busy, dropErr
    );
endinterface

// File: rtl/demux_scheduler.sv
// Round-robin sequencer for the 9-bit demultiplexor path: grant, settle,
// then strobe the chosen destination, dropping words stuck behind a busy one.
module demux_scheduler #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    demux_scheduler_if.slave bus
);
    localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE
    } state_t;

    state_t        state_q;
    logic          lastGrant_q;
    logic          holdDest_q;
    logic [CW-1:0] waitCnt_q;
    logic [8:0]    muxData_q;
    logic          muxSel_q;
    logic          loadA_q;
    logic          loadB_q;
    logic          dropErr_q;

    logic       gnt0;
    logic       gnt1;
    logic [8:0] muxData_d;
    logic       muxSel_d;
    logic       selBusy;
    logic       expired;

    // Both valid: the requester that did not win last time goes next.
    assign gnt0 = (state_q == IDLE) && bus.req0Valid
                  && (!bus.req1Valid || lastGrant_q);
    assign gnt1 = (state_q == IDLE) && bus.req1Valid
                  && (!bus.req0Valid || !lastGrant_q);

    assign muxData_d = gnt1 ? bus.req1Data : bus.req0Data;
    assign muxSel_d  = gnt1 ? bus.req1Dest : bus.req0Dest;

    assign selBusy = holdDest_q ? bus.destBusyB : bus.destBusyA;
    assign expired = (TIMEOUT != 0) && (waitCnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
            holdDest_q  <= 1'b0;
            waitCnt_q   <= '0;
            muxData_q   <= '0;
            muxSel_q    <= 1'b0;
            loadA_q     <= 1'b0;
            loadB_q     <= 1'b0;
            dropErr_q   <= 1'b0;
        end else begin
            loadA_q   <= 1'b0;
            loadB_q   <= 1'b0;
            dropErr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        muxData_q   <= muxData_d;
                        muxSel_q    <= muxSel_d;
                        holdDest_q  <= muxSel_d;
                        lastGrant_q <= gnt1;
                        waitCnt_q   <= '0;
                        state_q     <= SETUP;
                    end
                end
                SETUP: begin
                    if (!selBusy) begin
                        loadA_q <= !holdDest_q;
                        loadB_q <= holdDest_q;
                        state_q <= STROBE;
                    end else if (expired) begin
                        dropErr_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        waitCnt_q <= waitCnt_q + 1'b1;
                    end
                end
                STROBE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req0Ready = gnt0;
    assign bus.req1Ready = gnt1;
    assign bus.muxData   = muxData_q;
    assign bus.muxSel    = muxSel_q;
    assign bus.loadA     = loadA_q;
    assign bus.loadB     = loadB_q;
    assign bus.dropErr   = dropErr_q;
    assign bus.busy      = (state_q != IDLE);
endmodule
